register: RTL and testbench

- Parameterised N-bit general-purpose register: the storage element of the register file (R1–R4, T1–T4) and of other datapath registers.
- Each instance has a 2-bit function select (decrement / increment / load / clear) gated by a per-register enable.
- The register file drives `funsel` and `i` to all instances in common and selects targets through the individual `e` lines.

---
 rtl/reg_pkg.sv | 28 ++
 rtl/register.sv | 52 +++++
 tb/tb_register.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_pkg
// Description : Shared constants for the general-purpose datapath registers
//               (register file R1-R4, T1-T4 and other datapath registers) and
//               the control logic that drives them.
//               - FUNSEL_W    : width of the function-select bus
//               - FUNSEL_*    : function-select codes (dec / inc / load / clr)
//               - DATA_W      : default register width
// Revision    : 1.0 - initial release
// ============================================================================
package reg_pkg;

   // Width of the function-select bus shared by every register instance.
   localparam int FUNSEL_W = 2;

   // Function-select codes. The register file broadcasts one of these to all
   // registers and picks the target(s) through the per-register enables.
   localparam logic [FUNSEL_W-1:0] FUNSEL_DEC  = 2'b00;
   localparam logic [FUNSEL_W-1:0] FUNSEL_INC  = 2'b01;
   localparam logic [FUNSEL_W-1:0] FUNSEL_LOAD = 2'b10;
   localparam logic [FUNSEL_W-1:0] FUNSEL_CLR  = 2'b11;

   // Default datapath width.
   localparam int DATA_W = 8;

endpackage : reg_pkg
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
// Module      : register
// Description : Parameterised N-bit general-purpose register with a 2-bit
//               function select (decrement / increment / load / clear) gated
//               by a per-register enable. Wrap-around is silent and unsigned.
// Ports       :
//   clk     in   1          clock, all state changes on the rising edge
//   rst     in   1          synchronous active-high reset, highest priority
//   funsel  in   FUNSEL_W   operation select (see reg_pkg FUNSEL_* codes)
//   e       in   1          enable; 0 holds the register whatever funsel says
//   i       in   NBits      parallel load data
//   q       out  NBits      register contents, driven straight from state
// Revision    : 1.0 - initial release
// ============================================================================
module register
   import reg_pkg::*;
#(
   parameter int NBits = DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [FUNSEL_W-1:0] funsel,
   input  logic                e,
   input  logic [NBits-1:0]    i,
   output logic [NBits-1:0]    q
);

   logic [NBits-1:0] r_q;

   // Single state register; the next-state mux is the case on funsel.
   // Arithmetic is NBits wide, so dec of 0 and inc of all-ones wrap silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (e) begin
         case (funsel)
            FUNSEL_DEC:  r_q <= r_q - NBits'(1);
            FUNSEL_INC:  r_q <= r_q + NBits'(1);
            FUNSEL_LOAD: r_q <= i;
            FUNSEL_CLR:  r_q <= '0;
            // Only reachable with X/Z on funsel, which is illegal: hold.
            default:     r_q <= r_q;
         endcase
      end
   end

   // No combinational path from any input to q.
   assign q = r_q;

endmodule : register
`default_nettype wire

// File: tb/tb_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_register
// Description : Scoreboard bench for register. Three instances (8, 1 and 16
//               bits) share rst / e / funsel. A driver applies each operation
//               on the falling edge and pushes the reference-model result;
//               a monitor pops and compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register;
   import reg_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  funsel = 2'b00;
   logic        e = 1'b0;
   logic [7:0]  i8 = '0;
   logic [0:0]  i1 = '0;
   logic [15:0] i16 = '0;
   logic [7:0]  q8;
   logic [0:0]  q1;
   logic [15:0] q16;

   always #5 clk = ~clk;

   register #(.NBits(8)) u_dut8 (
      .clk(clk), .rst(rst), .funsel(funsel), .e(e), .i(i8), .q(q8)
   );
   register #(.NBits(1)) u_dut1 (
      .clk(clk), .rst(rst), .funsel(funsel), .e(e), .i(i1), .q(q1)
   );
   register #(.NBits(16)) u_dut16 (
      .clk(clk), .rst(rst), .funsel(funsel), .e(e), .i(i16), .q(q16)
   );

   typedef struct packed {
      logic [31:0] id;
      logic [7:0]  x8;
      logic [0:0]  x1;
      logic [15:0] x16;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;
   int step_id  = 0;

   // Reference values, held as plain integers modulo 2^width.
   int m8  = 0;
   int m1  = 0;
   int m16 = 0;

   function automatic int model_next(input int cur, input int width, input bit r,
                                     input bit en, input logic [1:0] fs, input int din);
      int modulus;
      modulus = 1 << width;
      if (r)   return 0;
      if (!en) return cur;
      case (fs)
         FUNSEL_DEC:  return (cur + modulus - 1) % modulus;
         FUNSEL_INC:  return (cur + 1) % modulus;
         FUNSEL_LOAD: return din % modulus;
         default:     return 0;
      endcase
   endfunction

   task automatic step(input bit r, input bit en, input logic [1:0] fs,
                       input logic [7:0] d8, input logic [15:0] d16);
      exp_t item;
      @(negedge clk);
      rst    = r;
      e      = en;
      funsel = fs;
      i8     = d8;
      i1     = d8[0];
      i16    = d16;
      m8  = model_next(m8,  8,  r, en, fs, int'(d8));
      m1  = model_next(m1,  1,  r, en, fs, int'(d8[0]));
      m16 = model_next(m16, 16, r, en, fs, int'(d16));
      item.id  = step_id;
      item.x8  = m8[7:0];
      item.x1  = m1[0:0];
      item.x16 = m16[15:0];
      sb.push_back(item);
      step_id++;
   endtask

   // Monitor: each pushed entry belongs to the very next rising edge.
   always @(posedge clk) begin
      exp_t got;
      #1;
      if (sb.size() != 0) begin
         got = sb.pop_front();
         n_checks++;
         if (q8 === got.x8) n_pass++;
         else $display("FAIL q8 step %0d: got %h expected %h", got.id, q8, got.x8);
         n_checks++;
         if (q1 === got.x1) n_pass++;
         else $display("FAIL q1 step %0d: got %h expected %h", got.id, q1, got.x1);
         n_checks++;
         if (q16 === got.x16) n_pass++;
         else $display("FAIL q16 step %0d: got %h expected %h", got.id, q16, got.x16);
      end
   end

   initial begin
      // Reset first: power-up contents are unspecified.
      step(1, 0, FUNSEL_DEC, 8'h00, 16'h0000);
      step(0, 1, FUNSEL_LOAD, 8'hA5, 16'h1234);
      // Reset wins over an enabled load.
      step(1, 1, FUNSEL_LOAD, 8'h3C, 16'hBEEF);
      step(0, 1, FUNSEL_LOAD, 8'h3C, 16'hBEEF);

      // Load then hold across all four codes with e=0.
      step(0, 1, FUNSEL_LOAD, 8'h5A, 16'h5A5A);
      for (int k = 0; k < 4; k++) step(0, 0, 2'(k), 8'hFF, 16'hFFFF);

      // Increment wrap.
      step(0, 1, FUNSEL_LOAD, 8'hFE, 16'hFFFE);
      for (int k = 0; k < 3; k++) step(0, 1, FUNSEL_INC, 8'h00, 16'h0000);

      // Decrement wrap.
      step(0, 1, FUNSEL_LOAD, 8'h01, 16'h0001);
      for (int k = 0; k < 3; k++) step(0, 1, FUNSEL_DEC, 8'h00, 16'h0000);

      // Mixed sequence ending in clear.
      step(0, 1, FUNSEL_LOAD, 8'h10, 16'h0010);
      step(0, 1, FUNSEL_INC,  8'h77, 16'h7777);
      step(0, 0, FUNSEL_CLR,  8'h77, 16'h7777);
      step(0, 1, FUNSEL_DEC,  8'h77, 16'h7777);
      step(0, 1, FUNSEL_CLR,  8'h77, 16'h7777);

      // From zero: the 1-bit instance goes 1 then 0.
      step(0, 1, FUNSEL_INC, 8'h00, 16'h0000);
      step(0, 1, FUNSEL_INC, 8'h00, 16'h0000);

      // 16-bit all-ones increments to zero.
      step(0, 1, FUNSEL_LOAD, 8'hFF, 16'hFFFF);
      step(0, 1, FUNSEL_INC,  8'h00, 16'h0000);

      // Randomised traffic with occasional resets.
      for (int k = 0; k < 300; k++) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom));
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_register
`default_nettype wire
